// File: rtl/bpu_update_queue.sv
`default_nettype none
// ============================================================================
// Module      : bpu_update_queue (with config_pkg)
// Description : Commit-side producer for the branch predictor update port.
//               Collects up to COMMIT_WIDTH resolved control-flow
//               instructions per cycle into a circular FIFO. Drains them in
//               program order, one per cycle, onto the BPU update interface.
// Ports       : clk_i, rst_i                    - clock, sync active-high reset
//               commit_*_i                      - per-slot commit group
//               commit_ready_o                  - whole group can be accepted
//               update_*_o                      - head entry towards the BPU
//               count_o                         - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================

package config_pkg;
    typedef struct packed {
        int unsigned PLEN;
    } cfg_t;

    localparam cfg_t EmptyCfg = '{PLEN: 32};
endpackage

module bpu_update_queue #(
    parameter config_pkg::cfg_t Cfg          = config_pkg::EmptyCfg,
    parameter int               COMMIT_WIDTH = 4,
    parameter int               DEPTH        = 8,
    localparam int              PLEN         = int'(Cfg.PLEN),
    localparam int              CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [COMMIT_WIDTH-1:0]            commit_valid_i,
    input  logic [COMMIT_WIDTH-1:0]            commit_is_cfi_i,
    input  logic [COMMIT_WIDTH-1:0]            commit_is_cond_i,
    input  logic [COMMIT_WIDTH-1:0]            commit_taken_i,
    input  logic [COMMIT_WIDTH-1:0][PLEN-1:0]  commit_pc_i,
    input  logic [COMMIT_WIDTH-1:0][PLEN-1:0]  commit_target_i,
    output logic                               commit_ready_o,
    output logic                               update_valid_o,
    output logic [PLEN-1:0]                    update_pc_o,
    output logic                               update_is_cond_o,
    output logic                               update_taken_o,
    output logic [PLEN-1:0]                    update_target_o,
    output logic [CNT_W-1:0]                   count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers and occupancy
    logic [PTR_W-1:0] r_head_q;
    logic [PTR_W-1:0] w_head_d;
    logic [PTR_W-1:0] r_tail_q;
    logic [PTR_W-1:0] w_tail_d;
    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] w_count_d;

    // Storage, deliberately without reset
    logic [PLEN-1:0]  r_pc_mem     [DEPTH];
    logic [PLEN-1:0]  r_target_mem [DEPTH];
    logic             r_cond_mem   [DEPTH];
    logic             r_taken_mem  [DEPTH];

    // Enqueue compaction
    logic [COMMIT_WIDTH-1:0] w_elig;
    logic [PTR_W-1:0]        w_wr_idx [COMMIT_WIDTH];
    logic [CNT_W-1:0]        w_k;
    logic [CNT_W-1:0]        w_k_acc;
    logic                    w_deq;

    // Ready depends on registered occupancy only: room for a worst-case group.
    assign commit_ready_o = (int'(r_count_q) + COMMIT_WIDTH) <= DEPTH;
    assign w_deq          = (r_count_q != '0);

    // Each eligible slot lands at tail plus the number of eligible slots below
    // it, which removes gaps left by non-CFI or invalid slots.
    always_comb begin
        w_k = '0;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            w_elig[i]   = commit_valid_i[i] & commit_is_cfi_i[i];
            w_wr_idx[i] = r_tail_q + PTR_W'(w_k);
            if (w_elig[i]) begin
                w_k = w_k + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_k_acc   = commit_ready_o ? w_k : '0;
        w_head_d  = r_head_q + PTR_W'(w_deq);
        w_tail_d  = r_tail_q + PTR_W'(w_k_acc);
        w_count_d = r_count_q + w_k_acc - CNT_W'(w_deq);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head_q  <= '0;
            r_tail_q  <= '0;
            r_count_q <= '0;
        end else begin
            r_head_q  <= w_head_d;
            r_tail_q  <= w_tail_d;
            r_count_q <= w_count_d;
        end
    end

    // Taken is normalised at write time so unconditional entries always read 1.
    always_ff @(posedge clk_i) begin
        if (!rst_i && commit_ready_o) begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (w_elig[i]) begin
                    r_pc_mem[w_wr_idx[i]]     <= commit_pc_i[i];
                    r_target_mem[w_wr_idx[i]] <= commit_target_i[i];
                    r_cond_mem[w_wr_idx[i]]   <= commit_is_cond_i[i];
                    r_taken_mem[w_wr_idx[i]]  <= commit_is_cond_i[i] ? commit_taken_i[i] : 1'b1;
                end
            end
        end
    end

    // Valid is derived from the count alone so uninitialised storage can
    // never leak X into it.
    assign update_valid_o   = w_deq;
    assign update_pc_o      = r_pc_mem[r_head_q];
    assign update_target_o  = r_target_mem[r_head_q];
    assign update_is_cond_o = r_cond_mem[r_head_q];
    assign update_taken_o   = r_taken_mem[r_head_q];
    assign count_o          = r_count_q;

endmodule
`default_nettype wire
